// File: rtl/regfile_ctrl.sv
// rtl/regfile_ctrl.sv - register file access sequencer; optional scoreboard enabled by REGFILE_CTRL_SCOREBOARD_EN
module regfile_ctrl #(
    parameter int DataWidth = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 rd_valid_i,
    output logic                 rd_ready_o,
    input  logic                 rd_need_a_i,
    input  logic                 rd_need_b_i,
    input  logic [4:0]           rd_addr_a_i,
    input  logic [4:0]           rd_addr_b_i,
    output logic                 rd_done_o,
    input  logic                 rd_ack_i,
    input  logic                 rsv_valid_i,
    input  logic [4:0]           rsv_addr_i,
    input  logic                 alu_wvalid_i,
    output logic                 alu_wready_o,
    input  logic [4:0]           alu_waddr_i,
    input  logic [DataWidth-1:0] alu_wdata_i,
    input  logic                 lsu_wvalid_i,
    output logic                 lsu_wready_o,
    input  logic [4:0]           lsu_waddr_i,
    input  logic [DataWidth-1:0] lsu_wdata_i,
    output logic                 req_ra_o,
    output logic                 req_rb_o,
    output logic                 req_w_o,
    output logic [4:0]           raddr_a_o,
    output logic [4:0]           raddr_b_o,
    output logic [4:0]           waddr_o,
    output logic [DataWidth-1:0] wdata_alu_o,
    output logic [DataWidth-1:0] wdata_lsu_o,
    output logic                 soursel_o
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RD_STROBE = 2'd1,
        RD_RESP   = 2'd2,
        WR_STROBE = 2'd3
    } state_e;

    state_e               state_q, state_d;
    logic                 rd_ready_q, rd_ready_d;
    logic                 rd_done_q, rd_done_d;
    logic                 req_ra_q, req_ra_d;
    logic                 req_rb_q, req_rb_d;
    logic                 req_w_q, req_w_d;
    logic                 alu_wready_q, alu_wready_d;
    logic                 lsu_wready_q, lsu_wready_d;
    logic [4:0]           raddr_a_q, raddr_a_d;
    logic [4:0]           raddr_b_q, raddr_b_d;
    logic [4:0]           waddr_q, waddr_d;
    logic [DataWidth-1:0] wdata_alu_q, wdata_alu_d;
    logic [DataWidth-1:0] wdata_lsu_q, wdata_lsu_d;
    logic                 soursel_q, soursel_d;
    // 1: LSU wins the next simultaneous writeback; flips to the loser after every grant
    logic                 rr_lsu_q, rr_lsu_d;
    logic                 hazard;
    logic                 grant_alu;

`ifdef REGFILE_CTRL_SCOREBOARD_EN
    logic [31:0] sb_q, sb_d;

    // Scoreboard update: the finishing writeback clears its bit, a same-cycle reservation re-sets it
    always_comb begin
        sb_d = sb_q;
        if (state_q == WR_STROBE) begin
            sb_d[waddr_q] = 1'b0;
        end
        if (rsv_valid_i && (rsv_addr_i != 5'd0)) begin
            sb_d[rsv_addr_i] = 1'b1;
        end
    end

    // Scoreboard storage
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign hazard = (rd_need_a_i && (rd_addr_a_i != 5'd0) && sb_q[rd_addr_a_i]) ||
                    (rd_need_b_i && (rd_addr_b_i != 5'd0) && sb_q[rd_addr_b_i]);
`else
    logic unused_rsv;
    assign unused_rsv = ^{rsv_valid_i, rsv_addr_i};
    assign hazard     = 1'b0;
`endif

    // Next-state and registered output decode; strobes default low so each lasts one cycle
    always_comb begin
        state_d      = state_q;
        rd_ready_d   = 1'b0;
        rd_done_d    = rd_done_q;
        req_ra_d     = 1'b0;
        req_rb_d     = 1'b0;
        req_w_d      = 1'b0;
        alu_wready_d = 1'b0;
        lsu_wready_d = 1'b0;
        raddr_a_d    = raddr_a_q;
        raddr_b_d    = raddr_b_q;
        waddr_d      = waddr_q;
        wdata_alu_d  = wdata_alu_q;
        wdata_lsu_d  = wdata_lsu_q;
        soursel_d    = soursel_q;
        rr_lsu_d     = rr_lsu_q;
        grant_alu    = alu_wvalid_i && (!lsu_wvalid_i || !rr_lsu_q);
        case (state_q)
            IDLE: begin
                if (alu_wvalid_i || lsu_wvalid_i) begin
                    state_d   = WR_STROBE;
                    soursel_d = grant_alu;
                    rr_lsu_d  = grant_alu;
                    if (grant_alu) begin
                        waddr_d      = alu_waddr_i;
                        wdata_alu_d  = alu_wdata_i;
                        alu_wready_d = 1'b1;
                        req_w_d      = (alu_waddr_i != 5'd0);
                    end else begin
                        waddr_d      = lsu_waddr_i;
                        wdata_lsu_d  = lsu_wdata_i;
                        lsu_wready_d = 1'b1;
                        req_w_d      = (lsu_waddr_i != 5'd0);
                    end
                end else if (rd_valid_i && !hazard) begin
                    state_d    = RD_STROBE;
                    rd_ready_d = 1'b1;
                    req_ra_d   = rd_need_a_i;
                    req_rb_d   = rd_need_b_i;
                    raddr_a_d  = rd_addr_a_i;
                    raddr_b_d  = rd_addr_b_i;
                end
            end
            WR_STROBE: begin
                state_d = IDLE;
            end
            RD_STROBE: begin
                state_d   = RD_RESP;
                rd_done_d = 1'b1;
            end
            RD_RESP: begin
                if (rd_ack_i) begin
                    rd_done_d = 1'b0;
                    state_d   = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            rd_ready_q   <= 1'b0;
            rd_done_q    <= 1'b0;
            req_ra_q     <= 1'b0;
            req_rb_q     <= 1'b0;
            req_w_q      <= 1'b0;
            alu_wready_q <= 1'b0;
            lsu_wready_q <= 1'b0;
            raddr_a_q    <= '0;
            raddr_b_q    <= '0;
            waddr_q      <= '0;
            wdata_alu_q  <= '0;
            wdata_lsu_q  <= '0;
            soursel_q    <= 1'b0;
            rr_lsu_q     <= 1'b1;
        end else begin
            state_q      <= state_d;
            rd_ready_q   <= rd_ready_d;
            rd_done_q    <= rd_done_d;
            req_ra_q     <= req_ra_d;
            req_rb_q     <= req_rb_d;
            req_w_q      <= req_w_d;
            alu_wready_q <= alu_wready_d;
            lsu_wready_q <= lsu_wready_d;
            raddr_a_q    <= raddr_a_d;
            raddr_b_q    <= raddr_b_d;
            waddr_q      <= waddr_d;
            wdata_alu_q  <= wdata_alu_d;
            wdata_lsu_q  <= wdata_lsu_d;
            soursel_q    <= soursel_d;
            rr_lsu_q     <= rr_lsu_d;
        end
    end

    assign rd_ready_o   = rd_ready_q;
    assign rd_done_o    = rd_done_q;
    assign req_ra_o     = req_ra_q;
    assign req_rb_o     = req_rb_q;
    assign req_w_o      = req_w_q;
    assign alu_wready_o = alu_wready_q;
    assign lsu_wready_o = lsu_wready_q;
    assign raddr_a_o    = raddr_a_q;
    assign raddr_b_o    = raddr_b_q;
    assign waddr_o      = waddr_q;
    assign wdata_alu_o  = wdata_alu_q;
    assign wdata_lsu_o  = wdata_lsu_q;
    assign soursel_o    = soursel_q;

endmodule

// File: tb/tb_regfile_ctrl.sv
// tb/tb_regfile_ctrl.sv - randomized self-checking bench for regfile_ctrl
`timescale 1ns/1ps
module tb_regfile_ctrl;

    localparam int DW = 32;
`ifdef REGFILE_CTRL_SCOREBOARD_EN
    localparam bit SB_EN = 1'b1;
`else
    localparam bit SB_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          rd_valid, rd_need_a, rd_need_b, rd_ack;
    logic [4:0]    rd_addr_a, rd_addr_b;
    logic          rsv_valid;
    logic [4:0]    rsv_addr;
    logic          alu_wvalid, lsu_wvalid;
    logic [4:0]    alu_waddr, lsu_waddr;
    logic [DW-1:0] alu_wdata, lsu_wdata;
    logic          rd_ready_o, rd_done_o, alu_wready_o, lsu_wready_o;
    logic          req_ra_o, req_rb_o, req_w_o, soursel_o;
    logic [4:0]    raddr_a_o, raddr_b_o, waddr_o;
    logic [DW-1:0] wdata_alu_o, wdata_lsu_o;

    int n_total = 0;
    int n_bad   = 0;

    // reference model: reserved registers and who won the last writeback grant
    bit sb_m[32];
    bit last_alu;

    always #5 clk = ~clk;

    regfile_ctrl #(.DataWidth(DW)) dut (
        .clk_i(clk), .rst_i(rst),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_ready_o),
        .rd_need_a_i(rd_need_a), .rd_need_b_i(rd_need_b),
        .rd_addr_a_i(rd_addr_a), .rd_addr_b_i(rd_addr_b),
        .rd_done_o(rd_done_o), .rd_ack_i(rd_ack),
        .rsv_valid_i(rsv_valid), .rsv_addr_i(rsv_addr),
        .alu_wvalid_i(alu_wvalid), .alu_wready_o(alu_wready_o),
        .alu_waddr_i(alu_waddr), .alu_wdata_i(alu_wdata),
        .lsu_wvalid_i(lsu_wvalid), .lsu_wready_o(lsu_wready_o),
        .lsu_waddr_i(lsu_waddr), .lsu_wdata_i(lsu_wdata),
        .req_ra_o(req_ra_o), .req_rb_o(req_rb_o), .req_w_o(req_w_o),
        .raddr_a_o(raddr_a_o), .raddr_b_o(raddr_b_o), .waddr_o(waddr_o),
        .wdata_alu_o(wdata_alu_o), .wdata_lsu_o(wdata_lsu_o),
        .soursel_o(soursel_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_reset();
        foreach (sb_m[i]) sb_m[i] = 1'b0;
        last_alu = 1'b1;
    endtask

    function automatic bit hazard_m(input logic [4:0] a, input logic [4:0] b, input bit na, input bit nb);
        return (na && (a != 5'd0) && sb_m[a]) || (nb && (b != 5'd0) && sb_m[b]);
    endfunction

    task automatic clear_inputs();
        rd_valid = 0; rd_need_a = 0; rd_need_b = 0; rd_ack = 0;
        rd_addr_a = 0; rd_addr_b = 0; rsv_valid = 0; rsv_addr = 0;
        alu_wvalid = 0; lsu_wvalid = 0; alu_waddr = 0; lsu_waddr = 0;
        alu_wdata = 0; lsu_wdata = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        tick();
    endtask

    task automatic do_reserve(input logic [4:0] addr);
        rsv_valid = 1'b1;
        rsv_addr  = addr;
        tick();
        rsv_valid = 1'b0;
        if (addr != 5'd0) sb_m[addr] = SB_EN;
    endtask

    task automatic do_write(input bit alu, input logic [4:0] addr, input logic [DW-1:0] data, input bit rsv_same);
        int lat;
        bit got;
        if (alu) begin
            alu_wvalid = 1; alu_waddr = addr; alu_wdata = data;
        end else begin
            lsu_wvalid = 1; lsu_waddr = addr; lsu_wdata = data;
        end
        lat = 0;
        got = 0;
        while (!got && lat < 8) begin
            tick();
            lat++;
            got = alu ? alu_wready_o : lsu_wready_o;
        end
        check("wr_lat", lat, 1);
        check("wr_other_rdy", alu ? lsu_wready_o : alu_wready_o, 0);
        check("wr_req_w", req_w_o, (addr != 5'd0));
        check("wr_addr", waddr_o, addr);
        check("wr_src", soursel_o, alu);
        check("wr_data", alu ? wdata_alu_o : wdata_lsu_o, data);
        check("wr_no_rd", {req_ra_o, req_rb_o, rd_ready_o}, 0);
        alu_wvalid = 0;
        lsu_wvalid = 0;
        if (rsv_same) begin
            rsv_valid = 1; rsv_addr = addr;
        end
        tick();
        rsv_valid = 0;
        check("wr_drop", {alu_wready_o, lsu_wready_o, req_w_o}, 0);
        last_alu = alu;
        if (addr != 5'd0) sb_m[addr] = rsv_same ? SB_EN : 1'b0;
    endtask

    task automatic do_conflict();
        logic [4:0]    aa, la;
        logic [DW-1:0] ad, ld;
        bit            first_alu, e;
        int            n, grants;
        aa = 5'($urandom_range(1, 31));
        la = 5'($urandom_range(1, 31));
        ad = DW'($urandom);
        ld = DW'($urandom);
        first_alu = !last_alu;
        alu_wvalid = 1; alu_waddr = aa; alu_wdata = ad;
        lsu_wvalid = 1; lsu_waddr = la; lsu_wdata = ld;
        n = 0;
        grants = 0;
        while (grants < 2 && n < 16) begin
            tick();
            n++;
            if (alu_wready_o || lsu_wready_o) begin
                e = (grants == 0) ? first_alu : !first_alu;
                check("cf_both_rdy", alu_wready_o & lsu_wready_o, 0);
                check("cf_order_alu", alu_wready_o, e);
                check("cf_src", soursel_o, e);
                check("cf_addr", waddr_o, e ? aa : la);
                if (alu_wready_o) alu_wvalid = 0;
                if (lsu_wready_o) lsu_wvalid = 0;
                grants++;
            end
        end
        check("cf_grants", grants, 2);
        alu_wvalid = 0;
        lsu_wvalid = 0;
        tick();
        check("cf_drop", {alu_wready_o, lsu_wready_o, req_w_o}, 0);
        last_alu = !first_alu;
        sb_m[aa] = 1'b0;
        sb_m[la] = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [4:0] b, input bit na, input bit nb,
                           input int ack_dly, input bit clr_alu);
        int lat;
        rd_valid = 1; rd_addr_a = a; rd_addr_b = b; rd_need_a = na; rd_need_b = nb;
        if (hazard_m(a, b, na, nb)) begin
            repeat (3) begin
                tick();
                check("rd_stall", {rd_ready_o, req_ra_o, req_rb_o}, 0);
            end
            if (na && (a != 5'd0) && sb_m[a]) do_write(clr_alu, a, DW'($urandom), 0);
            if (nb && (b != 5'd0) && sb_m[b]) do_write(clr_alu, b, DW'($urandom), 0);
        end
        lat = 0;
        do begin
            tick();
            lat++;
        end while (!rd_ready_o && lat < 8);
        check("rd_lat", lat, 1);
        check("rd_req_a", req_ra_o, na);
        check("rd_req_b", req_rb_o, nb);
        check("rd_addr_a", raddr_a_o, a);
        check("rd_addr_b", raddr_b_o, b);
        check("rd_no_w", req_w_o, 0);
        rd_valid = 0;
        tick();
        check("rd_pulse_end", {req_ra_o, req_rb_o, rd_ready_o}, 0);
        check("rd_done", rd_done_o, 1);
        for (int i = 0; i < ack_dly; i++) begin
            tick();
            check("rd_done_hold", rd_done_o, 1);
        end
        rd_ack = 1;
        tick();
        check("rd_done_drop", rd_done_o, 0);
        rd_ack = 0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        clear_inputs();
        model_reset();
        tick();
        check("rst_ready", {rd_ready_o, alu_wready_o, lsu_wready_o}, 0);
        check("rst_strobes", {req_ra_o, req_rb_o, req_w_o, rd_done_o}, 0);
        check("rst_addrs", {raddr_a_o, raddr_b_o, waddr_o, soursel_o}, 0);
        check("rst_wdata", {wdata_alu_o, wdata_lsu_o}, 0);
        do_reset();

        // simultaneous writebacks twice: LSU, ALU, LSU, ALU
        do_conflict();
        do_conflict();

        // ALU writes x5, then a read of A=5
        do_write(1'b1, 5'd5, 32'hDEADBEEF, 1'b0);
        do_read(5'd5, 5'd0, 1'b1, 1'b0, 0, 1'b0);

        // write to x0 handshakes without a register file write
        do_write(1'b0, 5'd0, 32'h1234_5678, 1'b0);

        // reserved x7 blocks a read until an LSU write retires it
        do_reserve(5'd7);
        do_read(5'd7, 5'd0, 1'b1, 1'b0, 1, 1'b0);

        // re-reserving x3 while its write retires keeps it reserved
        do_reserve(5'd3);
        do_write(1'b1, 5'd3, 32'hA5A5_0003, 1'b1);
        do_read(5'd0, 5'd3, 1'b0, 1'b1, 0, 1'b0);

        // reset during the read response
        do_reserve(5'd9);
        rd_valid = 1; rd_addr_a = 5'd0; rd_addr_b = 5'd0; rd_need_a = 1; rd_need_b = 0;
        tick();
        check("rr_accept", rd_ready_o, 1);
        rd_valid = 0;
        tick();
        check("rr_done", rd_done_o, 1);
        rst = 1'b1;
        #1;
        check("rr_rst_done", rd_done_o, 0);
        check("rr_rst_strobes", {req_ra_o, req_rb_o, req_w_o, rd_ready_o}, 0);
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        check("rr_after_done", rd_done_o, 0);
        do_read(5'd9, 5'd9, 1'b1, 1'b1, 0, 1'b1);

        // reset during a write strobe drops it with no later completion
        alu_wvalid = 1; alu_waddr = 5'd12; alu_wdata = 32'hCAFE_F00D;
        tick();
        check("rw_strobe", {alu_wready_o, req_w_o}, 2'b11);
        rst = 1'b1;
        #1;
        check("rw_rst_drop", {alu_wready_o, req_w_o}, 0);
        alu_wvalid = 0;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        check("rw_no_done", {alu_wready_o, lsu_wready_o, req_w_o}, 0);

        // randomized mix against the model
        for (int it = 0; it < 80; it++) begin
            case ($urandom_range(0, 3))
                0: do_write(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), DW'($urandom), 1'b0);
                1: do_reserve(5'($urandom_range(0, 7)));
                2: do_read(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
                default: do_conflict();
            endcase
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
